// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch mode controller.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_SET_HR  = 3'd3,
        ST_SET_MIN = 3'd4,
        ST_SET_SEC = 3'd5
    } st_e;

    localparam logic [1:0] FLD_NONE = 2'd0;
    localparam logic [1:0] FLD_HR   = 2'd1;
    localparam logic [1:0] FLD_MIN  = 2'd2;
    localparam logic [1:0] FLD_SEC  = 2'd3;

    localparam int CLK_HZ = 50000000;

    function automatic logic is_set_state(input st_e s);
        case (s)
            ST_SET_HR, ST_SET_MIN, ST_SET_SEC: is_set_state = 1'b1;
            default:                           is_set_state = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] field_of(input st_e s);
        case (s)
            ST_SET_HR:  field_of = FLD_HR;
            ST_SET_MIN: field_of = FLD_MIN;
            ST_SET_SEC: field_of = FLD_SEC;
            default:    field_of = FLD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Two-flop synchronizer plus stability counter for one active-low push-button.
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic stable,
    output logic press
);
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             stable_d_r;
    logic             armed_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronizers restart at the pressed level and presses stay masked until a
    // release is seen, so a key held through reset never yields a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            stable_r   <= 1'b1;
            stable_d_r <= 1'b1;
            armed_r    <= 1'b0;
            press_r    <= 1'b0;
            cnt_r      <= '0;
        end else begin
            sync1_r    <= raw_n;
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            press_r    <= armed_r & stable_d_r & ~stable_r;
            if (sync2_r) begin
                armed_r <= 1'b1;
            end
            if (sync2_r != stable_r) begin
                if (cnt_r == CNT_W'(DEB_CYCLES - 1)) begin
                    stable_r <= sync2_r;
                    cnt_r    <= '0;
                end else begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign stable = stable_r;
    assign press  = press_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: debounced keys, RUN/PAUSE/SET sequencing,
// count-enable prescaler, set-mode auto-repeat and display blink.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int DEB_CYCLES = 1000000,
    parameter int REPEAT_DLY = 25000000,
    parameter int REPEAT_PER = 10000000,
    parameter int BLINK_DIV  = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_n,
    input  logic       btn_mode_n,
    input  logic       btn_inc_n,
    output logic       run,
    output logic [2:0] state,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       lap_cap,
    output logic [1:0] set_field,
    output logic       set_inc,
    output logic       blink
);
    localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam int BLK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic start_press_s, mode_press_s, inc_press_s, inc_stable_s;
    logic start_stable_unused_s, mode_stable_unused_s;
    logic ev_start_s, ev_mode_s, ev_inc_s;

    st_e              state_r, next_st_s;
    logic             presc_clr_s, cnt_clr_s, lap_cap_s, cnt_en_s, set_inc_s;
    logic             rpt_hold_s, rpt_fire_s;
    logic [RPT_W-1:0] rpt_lim_s;
    logic [PRE_W-1:0] presc_r;
    logic [RPT_W-1:0] rpt_cnt_r;
    logic             rpt_act_r, rpt_rep_r;
    logic [BLK_W-1:0] blink_cnt_r;
    logic             blink_r, run_r, cnt_en_r, cnt_clr_r, lap_cap_r, set_inc_r;
    logic [1:0]       set_field_r;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk(clk), .rst(rst), .raw_n(btn_start_n), .stable(start_stable_unused_s), .press(start_press_s)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk(clk), .rst(rst), .raw_n(btn_mode_n), .stable(mode_stable_unused_s), .press(mode_press_s)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk(clk), .rst(rst), .raw_n(btn_inc_n), .stable(inc_stable_s), .press(inc_press_s)
    );

    assign ev_start_s = start_press_s;
    assign ev_mode_s  = mode_press_s & ~start_press_s;
    assign ev_inc_s   = inc_press_s & ~start_press_s & ~mode_press_s;
    assign cnt_en_s   = (state_r == ST_RUN) && (presc_r == PRE_W'(TICK_DIV - 1));

    // Next-state and action-pulse decode
    always_comb begin
        next_st_s   = state_r;
        presc_clr_s = 1'b0;
        cnt_clr_s   = 1'b0;
        lap_cap_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ev_start_s) begin
                    next_st_s   = ST_RUN;
                    presc_clr_s = 1'b1;
                end else if (ev_mode_s) begin
                    next_st_s = ST_SET_HR;
                end else begin
                    next_st_s = state_r;
                end
            end
            ST_RUN: begin
                if (ev_start_s) begin
                    next_st_s = ST_PAUSE;
                end else if (ev_mode_s) begin
                    lap_cap_s = 1'b1;
                end else begin
                    next_st_s = state_r;
                end
            end
            ST_PAUSE: begin
                if (ev_start_s) begin
                    next_st_s = ST_RUN;
                end else if (ev_mode_s) begin
                    next_st_s = ST_SET_HR;
                end else if (ev_inc_s) begin
                    next_st_s = ST_IDLE;
                    cnt_clr_s = 1'b1;
                end else begin
                    next_st_s = state_r;
                end
            end
            ST_SET_HR: begin
                if (ev_mode_s) next_st_s = ST_SET_MIN;
                else           next_st_s = state_r;
            end
            ST_SET_MIN: begin
                if (ev_mode_s) next_st_s = ST_SET_SEC;
                else           next_st_s = state_r;
            end
            ST_SET_SEC: begin
                if (ev_mode_s) next_st_s = ST_PAUSE;
                else           next_st_s = state_r;
            end
            default: next_st_s = ST_IDLE;
        endcase
    end

    // Auto-repeat only continues a hold that began with an accepted inc press
    always_comb begin
        rpt_lim_s  = rpt_rep_r ? RPT_W'(REPEAT_PER - 1) : RPT_W'(REPEAT_DLY - 1);
        rpt_hold_s = rpt_act_r & is_set_state(state_r) & ~inc_stable_s & ~ev_mode_s
                     & (next_st_s == state_r);
        rpt_fire_s = rpt_hold_s & (rpt_cnt_r == rpt_lim_s);
        set_inc_s  = (ev_inc_s & is_set_state(state_r)) | rpt_fire_s;
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            run_r       <= 1'b0;
            cnt_en_r    <= 1'b0;
            cnt_clr_r   <= 1'b0;
            lap_cap_r   <= 1'b0;
            set_inc_r   <= 1'b0;
            set_field_r <= FLD_NONE;
        end else begin
            state_r     <= next_st_s;
            run_r       <= (next_st_s == ST_RUN);
            cnt_en_r    <= cnt_en_s;
            cnt_clr_r   <= cnt_clr_s;
            lap_cap_r   <= lap_cap_s;
            set_inc_r   <= set_inc_s;
            set_field_r <= field_of(next_st_s);
        end
    end

    // Prescaler: cleared on a fresh start, advances only while in RUN
    always_ff @(posedge clk) begin
        if (rst || presc_clr_s) begin
            presc_r <= '0;
        end else if (state_r == ST_RUN) begin
            presc_r <= cnt_en_s ? '0 : presc_r + 1'b1;
        end else begin
            presc_r <= presc_r;
        end
    end

    // Auto-repeat counter for a held inc key in SET states
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_act_r <= 1'b0;
            rpt_rep_r <= 1'b0;
            rpt_cnt_r <= '0;
        end else if (ev_inc_s && is_set_state(state_r)) begin
            rpt_act_r <= 1'b1;
            rpt_rep_r <= 1'b0;
            rpt_cnt_r <= '0;
        end else if (!rpt_hold_s) begin
            rpt_act_r <= 1'b0;
            rpt_rep_r <= 1'b0;
            rpt_cnt_r <= '0;
        end else if (rpt_fire_s) begin
            rpt_rep_r <= 1'b1;
            rpt_cnt_r <= '0;
        end else begin
            rpt_cnt_r <= rpt_cnt_r + 1'b1;
        end
    end

    // Blink runs continuously across the SET states and is forced low elsewhere
    always_ff @(posedge clk) begin
        if (rst || !is_set_state(next_st_s)) begin
            blink_r     <= 1'b0;
            blink_cnt_r <= '0;
        end else if (is_set_state(state_r)) begin
            if (blink_cnt_r == BLK_W'(BLINK_DIV - 1)) begin
                blink_cnt_r <= '0;
                blink_r     <= ~blink_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + 1'b1;
            end
        end else begin
            blink_cnt_r <= blink_cnt_r;
        end
    end

    assign state     = state_r;
    assign run       = run_r;
    assign cnt_en    = cnt_en_r;
    assign cnt_clr   = cnt_clr_r;
    assign lap_cap   = lap_cap_r;
    assign set_inc   = set_inc_r;
    assign set_field = set_field_r;
    assign blink     = blink_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with small divider values.
module tb_stopwatch_ctrl;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_PAUSE = 3'd2;
    localparam logic [2:0] S_HR    = 3'd3;
    localparam logic [2:0] S_MIN   = 3'd4;
    localparam logic [2:0] S_SEC   = 3'd5;

    logic       clk, rst, btn_start_n, btn_mode_n, btn_inc_n;
    logic       run, cnt_en, cnt_clr, lap_cap, set_inc, blink;
    logic [2:0] state;
    logic [1:0] set_field;
    int         checks = 0;
    int         errors = 0;

    stopwatch_ctrl #(
        .TICK_DIV(10), .DEB_CYCLES(4), .REPEAT_DLY(20), .REPEAT_PER(5), .BLINK_DIV(3)
    ) dut (
        .clk(clk), .rst(rst), .btn_start_n(btn_start_n), .btn_mode_n(btn_mode_n),
        .btn_inc_n(btn_inc_n), .run(run), .state(state), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .lap_cap(lap_cap), .set_field(set_field), .set_inc(set_inc), .blink(blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_start_n = 1'b1; btn_mode_n = 1'b1; btn_inc_n = 1'b1;
        tick(3);
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, S_IDLE); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run: got %b want 0", run); end
        checks++; if ({cnt_en, cnt_clr, lap_cap, set_inc} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {cnt_en, cnt_clr, lap_cap, set_inc}); end
        checks++; if (set_field !== 2'd0) begin errors++; $display("FAIL reset_field: got %0d want 0", set_field); end
        checks++; if (blink !== 1'b0) begin errors++; $display("FAIL reset_blink: got %b want 0", blink); end
        rst = 1'b0;
        tick(10);
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_idle_after: got %0d want %0d", state, S_IDLE); end
    endtask

    task automatic test_glitch();
        for (int c = 0; c < 30; c++) begin
            if (c == 0 || c == 10) btn_start_n = 1'b0;
            if (c == 2 || c == 13) btn_start_n = 1'b1;
            tick(1);
            checks++; if (state !== S_IDLE) begin errors++; $display("FAIL glitch_state c=%0d: got %0d want %0d", c, state, S_IDLE); end
            checks++; if ({cnt_en, cnt_clr, lap_cap, set_inc} !== 4'b0000) begin errors++; $display("FAIL glitch_pulses c=%0d: got %b want 0000", c, {cnt_en, cnt_clr, lap_cap, set_inc}); end
        end
    endtask

    task automatic test_start_latency();
        btn_start_n = 1'b0;
        tick(7);
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL start_early: got %0d want %0d", state, S_IDLE); end
        tick(1);
        checks++; if (state !== S_RUN) begin errors++; $display("FAIL start_state: got %0d want %0d", state, S_RUN); end
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL start_run: got %b want 1", run); end
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (i == 2) btn_start_n = 1'b1;
            checks++; if (cnt_en !== ((i % 10) == 0)) begin errors++; $display("FAIL tick_cnt_en i=%0d: got %b want %b", i, cnt_en, (i % 10) == 0); end
            checks++; if (state !== S_RUN) begin errors++; $display("FAIL tick_state i=%0d: got %0d want %0d", i, state, S_RUN); end
        end
    endtask

    task automatic test_pause_resume();
        logic [2:0] st_exp;
        for (int c = 1; c <= 80; c++) begin
            tick(1);
            st_exp = (c < 15) ? S_RUN : (c < 73) ? S_PAUSE : S_RUN;
            checks++; if (state !== st_exp) begin errors++; $display("FAIL pause_state c=%0d: got %0d want %0d", c, state, st_exp); end
            checks++; if (run !== (st_exp == S_RUN)) begin errors++; $display("FAIL pause_run c=%0d: got %b want %b", c, run, st_exp == S_RUN); end
            checks++; if (cnt_en !== (c == 10 || c == 78)) begin errors++; $display("FAIL pause_cnt_en c=%0d: got %b want %b", c, cnt_en, c == 10 || c == 78); end
            if (c == 7 || c == 65) btn_start_n = 1'b0;
            if (c == 17 || c == 75) btn_start_n = 1'b1;
        end
    endtask

    task automatic test_lap_clear();
        logic [2:0] st_exp;
        btn_mode_n = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            tick(1);
            st_exp = (c < 28) ? S_RUN : (c < 48) ? S_PAUSE : S_IDLE;
            checks++; if (state !== st_exp) begin errors++; $display("FAIL lap_state c=%0d: got %0d want %0d", c, state, st_exp); end
            checks++; if (lap_cap !== (c == 8)) begin errors++; $display("FAIL lap_cap c=%0d: got %b want %b", c, lap_cap, c == 8); end
            checks++; if (cnt_clr !== (c == 48)) begin errors++; $display("FAIL cnt_clr c=%0d: got %b want %b", c, cnt_clr, c == 48); end
            if (c == 10) btn_mode_n = 1'b1;
            if (c == 20) btn_start_n = 1'b0;
            if (c == 30) btn_start_n = 1'b1;
            if (c == 40) btn_inc_n = 1'b0;
            if (c == 50) btn_inc_n = 1'b1;
        end
    endtask

    task automatic test_set_cycle();
        logic [2:0] st_exp;
        logic [1:0] fld_exp;
        logic       blk_exp;
        btn_mode_n = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            tick(1);
            st_exp  = (c < 8) ? S_IDLE : (c < 28) ? S_HR : (c < 48) ? S_MIN : (c < 68) ? S_SEC : S_PAUSE;
            fld_exp = (c < 8) ? 2'd0 : (c < 28) ? 2'd1 : (c < 48) ? 2'd2 : (c < 68) ? 2'd3 : 2'd0;
            blk_exp = (c >= 8 && c < 68) ? ((((c - 8) / 3) % 2) == 1) : 1'b0;
            checks++; if (state !== st_exp) begin errors++; $display("FAIL set_state c=%0d: got %0d want %0d", c, state, st_exp); end
            checks++; if (set_field !== fld_exp) begin errors++; $display("FAIL set_field c=%0d: got %0d want %0d", c, set_field, fld_exp); end
            checks++; if (blink !== blk_exp) begin errors++; $display("FAIL blink c=%0d: got %b want %b", c, blink, blk_exp); end
            if (c % 20 == 10) btn_mode_n = 1'b1;
            if (c % 20 == 0 && c <= 60) btn_mode_n = 1'b0;
        end
    endtask

    task automatic test_repeat();
        logic [2:0] st_exp;
        logic       inc_exp;
        int         d;
        btn_mode_n = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            tick(1);
            d       = c - 40;
            st_exp  = (c < 8) ? S_PAUSE : (c < 28) ? S_HR : S_MIN;
            inc_exp = (d == 8 || d == 28 || d == 33 || d == 38 || d == 43 || d == 48);
            checks++; if (state !== st_exp) begin errors++; $display("FAIL rpt_state c=%0d: got %0d want %0d", c, state, st_exp); end
            checks++; if (set_inc !== inc_exp) begin errors++; $display("FAIL rpt_set_inc c=%0d: got %b want %b", c, set_inc, inc_exp); end
            if (c >= 28) begin
                checks++; if (set_field !== 2'd2) begin errors++; $display("FAIL rpt_field c=%0d: got %0d want 2", c, set_field); end
            end
            if (c == 10 || c == 30) btn_mode_n = 1'b1;
            if (c == 20) btn_mode_n = 1'b0;
            if (c == 40) btn_inc_n = 1'b0;
            if (c == 84) btn_inc_n = 1'b1;
        end
    endtask

    task automatic test_back_to_back();
        btn_start_n = 1'b0;
        btn_inc_n   = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick(1);
            checks++; if (state !== S_MIN) begin errors++; $display("FAIL simul_state c=%0d: got %0d want %0d", c, state, S_MIN); end
            checks++; if (set_inc !== 1'b0) begin errors++; $display("FAIL simul_set_inc c=%0d: got %b want 0", c, set_inc); end
            if (c == 10) begin
                btn_start_n = 1'b1;
                btn_inc_n   = 1'b1;
            end
        end
    endtask

    task automatic test_reset_mid_press();
        btn_start_n = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(3);
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL midrst_state: got %0d want %0d", state, S_IDLE); end
        checks++; if (set_field !== 2'd0) begin errors++; $display("FAIL midrst_field: got %0d want 0", set_field); end
        rst = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            tick(1);
            checks++; if (state !== S_IDLE) begin errors++; $display("FAIL midrst_held c=%0d: got %0d want %0d", c, state, S_IDLE); end
        end
        btn_start_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick(1);
            checks++; if (state !== S_IDLE) begin errors++; $display("FAIL midrst_release c=%0d: got %0d want %0d", c, state, S_IDLE); end
        end
        btn_start_n = 1'b0;
        tick(7);
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL midrst_repress_early: got %0d want %0d", state, S_IDLE); end
        tick(1);
        checks++; if (state !== S_RUN) begin errors++; $display("FAIL midrst_repress: got %0d want %0d", state, S_RUN); end
        btn_start_n = 1'b1;
        tick(10);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_start_latency();
        test_pause_resume();
        test_lap_clear();
        test_set_cycle();
        test_repeat();
        test_back_to_back();
        test_reset_mid_press();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
